// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg: default sizing constants and pipeline-depth helper shared by the pipe_rca slice
package pipe_rca_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG_W = 8;
    function automatic int stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction
endpackage

// File: rtl/pipe_rca_if.sv
// pipe_rca_if: operand/result handshake bundle for pipe_rca
//   master (producer/consumer side): drives in_valid, a, b, cin, out_ready
//   slave  (adder side): drives in_ready, out_valid, sum, cout (and ovf under PIPE_RCA_OVF_EN)
interface pipe_rca_if import pipe_rca_pkg::*; #(parameter int WIDTH = DEF_WIDTH) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPE_RCA_OVF_EN
    logic             ovf;
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout, ovf);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, sum, cout);
    modport slave  (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/pipe_rca_seg.sv
// rca_seg: combinational W-bit ripple-carry adder segment
//   a, b : segment operands      ci : carry in
//   s    : segment sum           co : carry out    cm : carry into the segment MSB
module rca_seg #(parameter int W = 8) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         cm
);
    logic c;
    always_comb begin
        c  = ci;
        cm = ci;
        s  = '0;
        for (int i = 0; i < W; i++) begin
            cm   = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

// File: rtl/pipe_rca.sv
// pipe_rca: WIDTH-bit adder pipelined as WIDTH/SEG_W ripple-carry stages with a global valid/ready stall
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_rca_if.slave (in_valid/in_ready/a/b/cin in, out_valid/out_ready/sum/cout out)
//   PIPE_RCA_OVF_EN : adds the registered signed-overflow output bus.ovf
module pipe_rca import pipe_rca_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input logic     clk,
    input logic     rst_n,
    pipe_rca_if.slave bus
);
    localparam int STAGES = stages(WIDTH, SEG_W);

    if (SEG_W < 1 || WIDTH % SEG_W != 0) begin : g_bad_cfg
        $error("pipe_rca: WIDTH must be a positive multiple of SEG_W");
    end

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_ci;
    logic [STAGES-1:0] w_co;
    logic [STAGES-1:0] w_cm;
    logic [WIDTH-1:0]  w_a  [STAGES];
    logic [WIDTH-1:0]  w_b  [STAGES];
    logic [WIDTH-1:0]  w_s  [STAGES];
    logic [WIDTH-1:0]  w_sn [STAGES];
    logic [SEG_W-1:0]  w_seg [STAGES];
    logic              w_adv;

    // one global enable: the whole pipe moves unless the result is stuck at the output
    assign w_adv = !r_v[STAGES-1] || bus.out_ready;

    // stage inputs: stage 0 from the bus, later stages from the previous stage registers
    always_comb begin
        w_a[0]  = bus.a;
        w_b[0]  = bus.b;
        w_s[0]  = '0;
        w_ci[0] = bus.cin;
        w_v[0]  = bus.in_valid;
        for (int i = 1; i < STAGES; i++) begin
            w_a[i]  = r_a[i-1];
            w_b[i]  = r_b[i-1];
            w_s[i]  = r_s[i-1];
            w_ci[i] = r_c[i-1];
            w_v[i]  = r_v[i-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        rca_seg #(.W(SEG_W)) u_seg (
            .a  (w_a[k][k*SEG_W +: SEG_W]),
            .b  (w_b[k][k*SEG_W +: SEG_W]),
            .ci (w_ci[k]),
            .s  (w_seg[k]),
            .co (w_co[k]),
            .cm (w_cm[k])
        );
    end

    // merge each stage's fresh segment into the partial sum carried along the pipe
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            w_sn[i] = w_s[i];
            w_sn[i][i*SEG_W +: SEG_W] = w_seg[i];
        end
    end

`ifdef PIPE_RCA_OVF_EN
    logic r_ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            r_c <= '0;
            for (int i = 0; i < STAGES; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_s[i] <= '0;
            end
`ifdef PIPE_RCA_OVF_EN
            r_ovf <= 1'b0;
`endif
        end else if (w_adv) begin
            r_v <= w_v;
            r_c <= w_co;
            for (int i = 0; i < STAGES; i++) begin
                r_a[i] <= w_a[i];
                r_b[i] <= w_b[i];
                r_s[i] <= w_sn[i];
            end
`ifdef PIPE_RCA_OVF_EN
            r_ovf <= w_cm[STAGES-1] ^ w_co[STAGES-1];
`endif
        end
    end

    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v[STAGES-1];
    assign bus.sum       = r_s[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
`ifdef PIPE_RCA_OVF_EN
    assign bus.ovf       = r_ovf;
`endif
endmodule

// File: tb/tb_pipe_rca.sv
// tb_pipe_rca: self-checking bench for pipe_rca (WIDTH=16, SEG_W=4) with a queue scoreboard
`timescale 1ns/1ps
module tb_pipe_rca;
    import pipe_rca_pkg::*;
    localparam int W  = 16;
    localparam int SW = 4;
    localparam int ST = stages(W, SW);

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_rca_if #(.WIDTH(W)) bus ();
    pipe_rca #(.WIDTH(W), .SEG_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t q[$];
    exp_t e;
    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    int n_in  = 0;
    int nb;
    int target;
    longint t0;
    logic [W-1:0] cap;

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t r;
        logic [W:0] t;
        t   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.s = t[W-1:0];
        r.c = t[W];
        r.o = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        bus.cin = ci;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) chk("send_timeout", 32'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [W-1:0] s, input logic c);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = bus.out_valid;
        end
        chk({tag, "_valid"}, 32'(bus.out_valid), 1);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(s));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(c));
    endtask

    // scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.cin));
                n_in++;
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                chk("sb_out_expected", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_sum", 32'(bus.sum), 32'(e.s));
                    chk("sb_cout", 32'(bus.cout), 32'(e.c));
`ifdef PIPE_RCA_OVF_EN
                    chk("sb_ovf", 32'(bus.ovf), 32'(e.o));
`endif
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_cout", 32'(bus.cout), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        send(16'h1234, 16'h4321, 1'b0);
        bus.in_valid = 1'b0;
        repeat (ST - 1) begin
            @(negedge clk);
            chk("lat_early_valid", 32'(bus.out_valid), 0);
        end
        @(negedge clk);
        chk("lat_valid", 32'(bus.out_valid), 1);
        chk("single_sum", 32'(bus.sum), 32'h5555);
        chk("single_cout", 32'(bus.cout), 0);
        @(posedge clk);
        #1;

        send(16'hFFFF, 16'h0000, 1'b1);
        bus.in_valid = 1'b0;
        expect_out("wrap", 16'h0000, 1'b1);
        @(posedge clk);
        #1;
`ifdef PIPE_RCA_OVF_EN
        send(16'h7FFF, 16'h0001, 1'b0);
        bus.in_valid = 1'b0;
        expect_out("ovf", 16'h8000, 1'b0);
        chk("ovf_flag", 32'(bus.ovf), 1);
        @(posedge clk);
        #1;
`endif

        @(posedge clk);
        #1;
        t0 = $time;
        nb = n_out;
        for (int i = 0; i < 8; i++) send(W'(i), W'(i * 16'h1111), 1'b0);
        bus.in_valid = 1'b0;
        chk("b2b_accept_time", 32'($time - t0), 80);
        chk("b2b_early_out", 32'(n_out - nb), 32'(8 - ST));
        repeat (ST) begin
            @(negedge clk);
            chk("b2b_no_gap", 32'(bus.out_valid), 1);
        end
        @(negedge clk);
        chk("b2b_end", 32'(bus.out_valid), 0);

        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < ST; i++) send(W'(16'hA5A5 + i * 16'h0F0F), W'(16'h3C3C * (i + 1)), 1'(i));
        bus.in_valid = 1'b0;
        @(negedge clk);
        cap = bus.sum;
        chk("bp_valid", 32'(bus.out_valid), 1);
        repeat (5) begin
            @(negedge clk);
            chk("bp_sum_stable", 32'(bus.sum), 32'(cap));
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_valid_hold", 32'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        nb = n_out;
        bus.out_ready = 1'b1;
        repeat (ST + 2) @(negedge clk);
        chk("bp_drained", 32'(n_out - nb), 32'(ST));
        chk("bp_queue_empty", 32'(q.size()), 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(W'(16'h1111 * (i + 1)), W'(16'h0101), 1'b1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
        chk("mid_rst_sum", 32'(bus.sum), 0);
        chk("mid_rst_cout", 32'(bus.cout), 0);
`ifdef PIPE_RCA_OVF_EN
        chk("mid_rst_ovf", 32'(bus.ovf), 0);
`endif
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nb = n_out;
        repeat (10) @(negedge clk);
        chk("rst_no_ghost", 32'(n_out - nb), 0);

        @(posedge clk);
        #1;
        target = n_in + 10000;
        for (int c = 0; c < 60000 && n_in < target; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
            bus.cin = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        chk("rand_count_reached", 32'(n_in >= target), 1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (ST + 2) @(negedge clk);
        chk("final_queue_empty", 32'(q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
